// File: rtl/axis_pkg.sv
// Shared AXI-Stream helpers for the width converters and stream FIFOs.
package axis_pkg;

   localparam int unsigned AXIS_BYTE = 8;

   // Counter width that never collapses to zero bits for a single-entry range.
   function automatic int unsigned safe_clog2(input int unsigned value);
      return (value > 1) ? $clog2(value) : 1;
   endfunction

endpackage

// File: rtl/axis_width_downsizer.sv
// AXI-Stream downsizer: one wide beat of ratio lanes is replayed as ratio narrow beats,
// lowest lane first, from a registered holding slot.
module axis_width_downsizer
   import axis_pkg::*;
#(
   parameter int unsigned n     = 5,
   parameter int unsigned ratio = 2,
   parameter int unsigned nb    = n * AXIS_BYTE,
   parameter int unsigned cw    = safe_clog2(ratio)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ratio*nb-1:0] in_tdata,
   input  logic                in_tlast,
   input  logic                in_tvalid,
   output logic                in_tready,
   output logic [nb-1:0]       out_tdata,
   output logic                out_tlast,
   output logic                out_tvalid,
   input  logic                out_tready,
   output logic                busy
);

   if (ratio < 1 || ratio > 16) begin : g_bad_ratio
      $error("axis_width_downsizer: ratio must be within 1..16");
   end

   localparam logic [cw-1:0] LastIdx = cw'(ratio - 1);

   logic [ratio*nb-1:0] hold_q, hold_d;
   logic                hold_last_q, hold_last_d;
   logic [cw-1:0]       idx_q, idx_d;
   logic                full_q, full_d;
   logic                last_lane;
   logic                in_hs;
   logic                out_hs;

   assign last_lane = (idx_q == LastIdx);

   // Reload is allowed while the final lane drains, giving gap-free back-to-back beats.
   assign in_tready = reset_n & (~full_q | (last_lane & out_tready));
   assign in_hs     = in_tvalid & in_tready;
   assign out_hs    = full_q & out_tready;

   always_comb begin
      hold_d      = hold_q;
      hold_last_d = hold_last_q;
      idx_d       = idx_q;
      full_d      = full_q;
      if (in_hs) begin
         hold_d      = in_tdata;
         hold_last_d = in_tlast;
         idx_d       = '0;
         full_d      = 1'b1;
      end else if (out_hs) begin
         if (last_lane) begin
            idx_d  = '0;
            full_d = 1'b0;
         end else begin
            idx_d = idx_q + cw'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_q      <= '0;
         hold_last_q <= 1'b0;
         idx_q       <= '0;
         full_q      <= 1'b0;
      end else begin
         hold_q      <= hold_d;
         hold_last_q <= hold_last_d;
         idx_q       <= idx_d;
         full_q      <= full_d;
      end
   end

   // Lane select from registered state only; no path from in_* to out_*.
   always_comb begin
      out_tdata = '0;
      for (int unsigned k = 0; k < ratio; k++) begin
         if (idx_q == cw'(k)) begin
            out_tdata = hold_q[k*nb +: nb];
         end
      end
   end

   assign out_tlast  = hold_last_q & last_lane;
   assign out_tvalid = full_q;
   assign busy       = full_q;

endmodule

// File: tb/tb_axis_width_downsizer.sv
// Scoreboard bench for axis_width_downsizer across four parameter sets.
module tb_axis_width_downsizer;

   typedef struct packed {
      logic [39:0] data;
      logic        last;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // a: n=1 ratio=4, b: n=5 ratio=2, c: n=1 ratio=2, d: n=2 ratio=1
   logic [31:0] a_in_tdata;  logic a_in_tlast, a_in_tvalid, a_in_tready;
   logic [7:0]  a_out_tdata; logic a_out_tlast, a_out_tvalid, a_out_tready, a_busy;
   logic [79:0] b_in_tdata;  logic b_in_tlast, b_in_tvalid, b_in_tready;
   logic [39:0] b_out_tdata; logic b_out_tlast, b_out_tvalid, b_out_tready, b_busy;
   logic [15:0] c_in_tdata;  logic c_in_tlast, c_in_tvalid, c_in_tready;
   logic [7:0]  c_out_tdata; logic c_out_tlast, c_out_tvalid, c_out_tready, c_busy;
   logic [15:0] d_in_tdata;  logic d_in_tlast, d_in_tvalid, d_in_tready;
   logic [15:0] d_out_tdata; logic d_out_tlast, d_out_tvalid, d_out_tready, d_busy;

   exp_t a_q[$], b_q[$], c_q[$], d_q[$];
   exp_t a_exp, b_exp, c_exp, d_exp;
   int   a_nout = 0, b_nout = 0, c_nout = 0, d_nout = 0;
   int   b_first_cyc = 0, b_last_cyc = 0;
   int   c_nlast = 0, c_lastpos = 0;

   axis_width_downsizer #(.n(1), .ratio(4)) u_a (
      .clk(clk), .reset_n(reset_n),
      .in_tdata(a_in_tdata), .in_tlast(a_in_tlast), .in_tvalid(a_in_tvalid),
      .in_tready(a_in_tready), .out_tdata(a_out_tdata), .out_tlast(a_out_tlast),
      .out_tvalid(a_out_tvalid), .out_tready(a_out_tready), .busy(a_busy)
   );

   axis_width_downsizer u_b (
      .clk(clk), .reset_n(reset_n),
      .in_tdata(b_in_tdata), .in_tlast(b_in_tlast), .in_tvalid(b_in_tvalid),
      .in_tready(b_in_tready), .out_tdata(b_out_tdata), .out_tlast(b_out_tlast),
      .out_tvalid(b_out_tvalid), .out_tready(b_out_tready), .busy(b_busy)
   );

   axis_width_downsizer #(.n(1), .ratio(2)) u_c (
      .clk(clk), .reset_n(reset_n),
      .in_tdata(c_in_tdata), .in_tlast(c_in_tlast), .in_tvalid(c_in_tvalid),
      .in_tready(c_in_tready), .out_tdata(c_out_tdata), .out_tlast(c_out_tlast),
      .out_tvalid(c_out_tvalid), .out_tready(c_out_tready), .busy(c_busy)
   );

   axis_width_downsizer #(.n(2), .ratio(1)) u_d (
      .clk(clk), .reset_n(reset_n),
      .in_tdata(d_in_tdata), .in_tlast(d_in_tlast), .in_tvalid(d_in_tvalid),
      .in_tready(d_in_tready), .out_tdata(d_out_tdata), .out_tlast(d_out_tlast),
      .out_tvalid(d_out_tvalid), .out_tready(d_out_tready), .busy(d_busy)
   );

   // Scoreboard pops: every output handshake is compared with the oldest expected lane.
   always @(negedge clk) begin
      if (reset_n && a_out_tvalid && a_out_tready) begin
         total++;
         if (a_q.size() == 0) begin
            bad++;
            $display("FAIL a_extra_beat: got data=%h last=%b, required no beat", a_out_tdata, a_out_tlast);
         end else begin
            a_exp = a_q.pop_front();
            if (a_out_tdata !== a_exp.data[7:0] || a_out_tlast !== a_exp.last) begin
               bad++;
               $display("FAIL a_beat: got data=%h last=%b, required data=%h last=%b",
                        a_out_tdata, a_out_tlast, a_exp.data[7:0], a_exp.last);
            end
         end
         a_nout++;
      end
   end

   always @(negedge clk) begin
      if (reset_n && b_out_tvalid && b_out_tready) begin
         total++;
         if (b_q.size() == 0) begin
            bad++;
            $display("FAIL b_extra_beat: got data=%h last=%b, required no beat", b_out_tdata, b_out_tlast);
         end else begin
            b_exp = b_q.pop_front();
            if (b_out_tdata !== b_exp.data || b_out_tlast !== b_exp.last) begin
               bad++;
               $display("FAIL b_beat: got data=%h last=%b, required data=%h last=%b",
                        b_out_tdata, b_out_tlast, b_exp.data, b_exp.last);
            end
         end
         if (b_nout == 0) b_first_cyc = cyc;
         b_last_cyc = cyc;
         b_nout++;
      end
   end

   always @(negedge clk) begin
      if (reset_n && c_out_tvalid && c_out_tready) begin
         total++;
         if (c_q.size() == 0) begin
            bad++;
            $display("FAIL c_extra_beat: got data=%h last=%b, required no beat", c_out_tdata, c_out_tlast);
         end else begin
            c_exp = c_q.pop_front();
            if (c_out_tdata !== c_exp.data[7:0] || c_out_tlast !== c_exp.last) begin
               bad++;
               $display("FAIL c_beat: got data=%h last=%b, required data=%h last=%b",
                        c_out_tdata, c_out_tlast, c_exp.data[7:0], c_exp.last);
            end
         end
         c_nout++;
         if (c_out_tlast) begin
            c_nlast++;
            c_lastpos = c_nout;
         end
      end
   end

   always @(negedge clk) begin
      if (reset_n && d_out_tvalid && d_out_tready) begin
         total++;
         if (d_q.size() == 0) begin
            bad++;
            $display("FAIL d_extra_beat: got data=%h, required no beat", d_out_tdata);
         end else begin
            d_exp = d_q.pop_front();
            if (d_out_tdata !== d_exp.data[15:0] || d_out_tlast !== d_exp.last) begin
               bad++;
               $display("FAIL d_beat: got data=%h last=%b, required data=%h last=%b",
                        d_out_tdata, d_out_tlast, d_exp.data[15:0], d_exp.last);
            end
         end
         d_nout++;
      end
   end

   // Drivers: present a beat, wait (bounded) for the handshake, push its expected lanes.
   task automatic a_send(input logic [31:0] d, input logic l, output int waits);
      exp_t e;
      a_in_tdata = d; a_in_tlast = l; a_in_tvalid = 1'b1; waits = 0;
      do begin @(negedge clk); waits++; end while (!a_in_tready && waits < 200);
      if (!a_in_tready) begin
         total++; bad++;
         $display("FAIL a_send_timeout: in_tready=%b after %0d cycles, required 1", a_in_tready, waits);
      end else begin
         for (int k = 0; k < 4; k++) begin
            e.data = 40'(d[k*8 +: 8]); e.last = l && (k == 3);
            a_q.push_back(e);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic b_send(input logic [79:0] d, input logic l, output int waits);
      exp_t e;
      b_in_tdata = d; b_in_tlast = l; b_in_tvalid = 1'b1; waits = 0;
      do begin @(negedge clk); waits++; end while (!b_in_tready && waits < 200);
      if (!b_in_tready) begin
         total++; bad++;
         $display("FAIL b_send_timeout: in_tready=%b after %0d cycles, required 1", b_in_tready, waits);
      end else begin
         for (int k = 0; k < 2; k++) begin
            e.data = d[k*40 +: 40]; e.last = l && (k == 1);
            b_q.push_back(e);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic c_send(input logic [15:0] d, input logic l);
      exp_t e;
      int   waits;
      c_in_tdata = d; c_in_tlast = l; c_in_tvalid = 1'b1; waits = 0;
      do begin @(negedge clk); waits++; end while (!c_in_tready && waits < 200);
      if (!c_in_tready) begin
         total++; bad++;
         $display("FAIL c_send_timeout: in_tready=%b after %0d cycles, required 1", c_in_tready, waits);
      end else begin
         for (int k = 0; k < 2; k++) begin
            e.data = 40'(d[k*8 +: 8]); e.last = l && (k == 1);
            c_q.push_back(e);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      #1 reset_n = 1'b0;
      #2;
      total++;
      if ({a_out_tvalid, a_busy, a_out_tlast, a_out_tdata} !== 11'd0) begin
         bad++;
         $display("FAIL reset_a_outputs: got valid=%b busy=%b last=%b data=%h, required all 0",
                  a_out_tvalid, a_busy, a_out_tlast, a_out_tdata);
      end
      total++;
      if ({b_out_tvalid, b_busy, b_out_tdata, d_out_tvalid, d_out_tdata} !== 59'd0) begin
         bad++;
         $display("FAIL reset_bd_outputs: got b_valid=%b b_data=%h d_valid=%b d_data=%h, required 0",
                  b_out_tvalid, b_out_tdata, d_out_tvalid, d_out_tdata);
      end
      total++;
      if ({a_in_tready, b_in_tready, c_in_tready, d_in_tready} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_in_tready: got %b, required 0000",
                  {a_in_tready, b_in_tready, c_in_tready, d_in_tready});
      end
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      total++;
      if ({a_in_tready, b_in_tready, c_in_tready, d_in_tready} !== 4'b1111) begin
         bad++;
         $display("FAIL release_in_tready: got %b, required 1111",
                  {a_in_tready, b_in_tready, c_in_tready, d_in_tready});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single_beat;
      int         waits;
      logic [3:0] exp_rdy;
      logic [7:0] exp_lane;
      logic [31:0] word;
      word = 32'hDDCCBBAA;
      exp_rdy = 4'b1000;
      a_out_tready = 1'b1;
      a_send(word, 1'b1, waits);
      a_in_tvalid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         exp_lane = word[k*8 +: 8];
         total++;
         if (a_out_tvalid !== 1'b1 || a_out_tdata !== exp_lane) begin
            bad++;
            $display("FAIL single_lane%0d: got valid=%b data=%h, required valid=1 data=%h",
                     k, a_out_tvalid, a_out_tdata, exp_lane);
         end
         total++;
         if (a_in_tready !== exp_rdy[k]) begin
            bad++;
            $display("FAIL single_ready%0d: got in_tready=%b, required %b", k, a_in_tready, exp_rdy[k]);
         end
      end
      @(negedge clk);
      total++;
      if (a_out_tvalid !== 1'b0 || a_busy !== 1'b0) begin
         bad++;
         $display("FAIL single_drained: got valid=%b busy=%b, required 0 0", a_out_tvalid, a_busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      int waits;
      b_out_tready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         b_send(80'({$urandom, $urandom, $urandom}), i == 7, waits);
         total++;
         if (waits != ((i == 0) ? 1 : 2)) begin
            bad++;
            $display("FAIL b2b_ready_beat%0d: got %0d cycles to accept, required %0d",
                     i, waits, (i == 0) ? 1 : 2);
         end
      end
      b_in_tvalid = 1'b0;
      for (int c = 0; c < 100 && b_nout < 16; c++) @(negedge clk);
      total++;
      if (b_nout != 16 || b_q.size() != 0) begin
         bad++;
         $display("FAIL b2b_count: got %0d beats with %0d pending, required 16 and 0", b_nout, b_q.size());
      end
      total++;
      if (b_last_cyc - b_first_cyc != 15) begin
         bad++;
         $display("FAIL b2b_no_bubble: got span=%0d cycles, required 15", b_last_cyc - b_first_cyc);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure;
      int         target, waits;
      logic       stall;
      logic [8:0] held;
      void'($urandom(32'd2024));
      target = a_nout + 400;
      stall  = 1'b0;
      held   = '0;
      fork
         begin
            for (int i = 0; i < 100; i++) begin
               a_send($urandom, $urandom_range(0, 3) == 0, waits);
               if ($urandom_range(0, 3) == 0) begin
                  a_in_tvalid = 1'b0;
                  @(posedge clk); #1;
               end
            end
            a_in_tvalid = 1'b0;
         end
         begin
            for (int c = 0; c < 4000 && a_nout < target; c++) begin
               @(negedge clk);
               if (stall) begin
                  total++;
                  if (a_out_tvalid !== 1'b1 || {a_out_tdata, a_out_tlast} !== held) begin
                     bad++;
                     $display("FAIL bp_stable: got valid=%b data/last=%h, required 1 %h",
                              a_out_tvalid, {a_out_tdata, a_out_tlast}, held);
                  end
               end
               stall = a_out_tvalid && !a_out_tready;
               held  = {a_out_tdata, a_out_tlast};
               @(posedge clk); #1;
               a_out_tready = ($urandom_range(0, 1) == 1);
            end
            a_out_tready = 1'b1;
         end
      join
      for (int c = 0; c < 100 && a_nout < target; c++) @(negedge clk);
      total++;
      if (a_nout != target || a_q.size() != 0) begin
         bad++;
         $display("FAIL bp_count: got %0d of %0d beats, %0d pending, required all and 0",
                  a_nout - (target - 400), 400, a_q.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_tlast;
      c_out_tready = 1'b1;
      c_send(16'hB1A1, 1'b0);
      c_send(16'hB2A2, 1'b0);
      c_send(16'hB3A3, 1'b1);
      c_in_tvalid = 1'b0;
      for (int c = 0; c < 50 && c_nout < 6; c++) @(negedge clk);
      total++;
      if (c_nout != 6 || c_nlast != 1 || c_lastpos != 6) begin
         bad++;
         $display("FAIL tlast_position: got beats=%0d lasts=%0d at beat %0d, required 6 1 6",
                  c_nout, c_nlast, c_lastpos);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_async_reset;
      int          waits;
      logic [7:0]  exp_lane;
      logic [31:0] word;
      a_out_tready = 1'b1;
      a_send(32'hDDCCBBAA, 1'b1, waits);
      a_in_tvalid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(posedge clk); #3;
      reset_n = 1'b0;
      #1;
      total++;
      if ({a_out_tvalid, a_busy, a_in_tready, a_out_tdata} !== 11'd0) begin
         bad++;
         $display("FAIL async_reset: got valid=%b busy=%b ready=%b data=%h, required all 0",
                  a_out_tvalid, a_busy, a_in_tready, a_out_tdata);
      end
      a_q.delete();
      @(posedge clk); #1;
      reset_n = 1'b1;
      word = 32'h44332211;
      a_send(word, 1'b0, waits);
      a_in_tvalid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         exp_lane = word[k*8 +: 8];
         total++;
         if (a_out_tvalid !== 1'b1 || a_out_tdata !== exp_lane) begin
            bad++;
            $display("FAIL after_reset_lane%0d: got valid=%b data=%h, required 1 %h",
                     k, a_out_tvalid, a_out_tdata, exp_lane);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_ratio1;
      exp_t e;
      int   base;
      base = d_nout;
      d_out_tready = 1'b1;
      d_in_tdata = 16'h1234; d_in_tlast = 1'b0; d_in_tvalid = 1'b1;
      @(negedge clk);
      total++;
      if (d_in_tready !== 1'b1) begin
         bad++;
         $display("FAIL r1_first_ready: got in_tready=%b, required 1", d_in_tready);
      end
      e.data = 40'h1234; e.last = 1'b0; d_q.push_back(e);
      @(posedge clk); #1;
      d_in_tdata = 16'h5678; d_out_tready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total++;
         if (d_out_tvalid !== 1'b1 || d_out_tdata !== 16'h1234 || d_in_tready !== 1'b0) begin
            bad++;
            $display("FAIL r1_stall%0d: got valid=%b data=%h ready=%b, required 1 1234 0",
                     k, d_out_tvalid, d_out_tdata, d_in_tready);
         end
      end
      @(posedge clk); #1;
      d_out_tready = 1'b1;
      @(negedge clk);
      total++;
      if (d_in_tready !== 1'b1) begin
         bad++;
         $display("FAIL r1_pass_ready: got in_tready=%b, required 1", d_in_tready);
      end
      e.data = 40'h5678; d_q.push_back(e);
      @(posedge clk); #1;
      d_in_tvalid = 1'b0;
      @(negedge clk);
      total++;
      if (d_out_tvalid !== 1'b1 || d_out_tdata !== 16'h5678) begin
         bad++;
         $display("FAIL r1_second: got valid=%b data=%h, required 1 5678", d_out_tvalid, d_out_tdata);
      end
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (d_out_tvalid !== 1'b0 || d_nout - base != 2 || d_q.size() != 0) begin
         bad++;
         $display("FAIL r1_count: got valid=%b beats=%0d pending=%0d, required 0 2 0",
                  d_out_tvalid, d_nout - base, d_q.size());
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      a_in_tdata = '0; a_in_tlast = 1'b0; a_in_tvalid = 1'b0; a_out_tready = 1'b0;
      b_in_tdata = '0; b_in_tlast = 1'b0; b_in_tvalid = 1'b0; b_out_tready = 1'b0;
      c_in_tdata = '0; c_in_tlast = 1'b0; c_in_tvalid = 1'b0; c_out_tready = 1'b0;
      d_in_tdata = '0; d_in_tlast = 1'b0; d_in_tvalid = 1'b0; d_out_tready = 1'b0;
      test_reset();
      test_single_beat();
      test_back_to_back();
      test_backpressure();
      test_tlast();
      test_async_reset();
      test_ratio1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axis_width_downsizer.md
Name: axis_width_downsizer

Overview:
- AXI-Stream width converter. Accepts one wide beat of `ratio` × `nb` bits and emits it as `ratio` consecutive narrow beats of `nb` bits, lowest lane first.
- Generational successor to the fixed 2:1 pass-through adapter in the stream template. It adds registered output, lane serialisation, tlast propagation and full-throughput back-to-back acceptance.
- Sits between a wide producer (DMA or packer) and a narrow consumer inside the AXI-Stream test template.

Parameters:
- n, 5, bytes per output lane
- ratio, 2, input lanes per input beat; legal range 1..16
- nb, n*8, bits per output lane (derived; do not override)
- cw, (ratio>1 ? $clog2(ratio) : 1), lane counter width (derived)

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- in_tdata  input  ratio*nb  wide input beat; lane k = bits [k*nb +: nb]
- in_tlast  input  1  1 - last wide beat of packet
- in_tvalid  input  1  1 - input data is valid
- in_tready  output  1  1 - ready to accept input beat
- out_tdata  output  nb  narrow output lane
- out_tlast  output  1  1 - last narrow beat of packet
- out_tvalid  output  1  1 - output data is valid
- out_tready  input  1  1 - downstream ready
- busy  output  1  1 - holding register occupied (out_tvalid copy, for status)

Behaviour:
- Clock and reset: single clock `clk`. Reset is asynchronous and active-low on `reset_n`. All flops clear immediately on reset_n=0.
- Reset values: out_tvalid=0, out_tlast=0, out_tdata=0, busy=0, lane counter idx=0, holding register=0.
- Ready during reset: in_tready is forced to 0 while reset_n=0.
- State: holding register `hold` (ratio*nb bits), `hold_last` (1 bit), `idx` (cw bits), `full` (1 bit). out_tvalid = full.
- Output mapping: out_tdata = hold lane[idx]. out_tlast = hold_last & (idx == ratio-1). Both are registered-state driven, with no combinational path from in_* to out_*.
- Input ready: in_tready = reset_n & (!full | (idx == ratio-1 & out_tready)). Combinational from out_tready only.
- Input handshake (in_tvalid & in_tready): on the next edge hold <= in_tdata, hold_last <= in_tlast, idx <= 0, full <= 1.
- Output handshake (out_tvalid & out_tready):
  - idx != ratio-1: idx <= idx+1.
  - idx == ratio-1 with no simultaneous input handshake: full <= 0, idx <= 0.
- Simultaneous last-lane output and new input in the same cycle: the load wins. There is no bubble, so sustained throughput is exactly one input beat per `ratio` cycles when out_tready is held at 1.
- Latency: the first lane appears on out_* in the cycle after the input handshake (1 cycle).
- Stalls:
  - out_tready=0: all state holds.
  - While out_tvalid=1, out_tdata and out_tlast are stable until accepted (AXI rule).
- ratio=1: degenerates to a one-deep registered slice. idx stays 0; in_tready = reset_n & (!full | out_tready).
- Reset mid-operation: partially emitted beats are discarded. After release, the first accepted beat starts again at lane 0.
- in_tvalid when not ready: ignored; the producer must hold its data per AXI.

Decomposition:
- Package `axis_pkg`: function `safe_clog2(int)` (returns at least 1) and localparam `AXIS_BYTE = 8`. Shared with future upsizer and FIFO blocks.
- No sub-module required. An `axis_upsizer` counterpart reuses the same package and is built separately.

Test Plan:
- Single beat, n=1, ratio=4. Input in_tdata=32'hDDCCBBAA, in_tlast=1, out_tready=1 → out_tdata sequence AA, BB, CC, DD on 4 consecutive cycles starting 1 cycle after handshake. out_tlast=1 only with DD. in_tready=0 during BB and CC, then 1 during DD.
- Back-to-back, defaults (n=5, ratio=2). Drive 8 wide beats with in_tvalid held at 1 and out_tready=1 → 16 narrow beats with no idle cycle, lane order low then high; in_tready pattern 1,0,1,0,….
- Backpressure, n=1, ratio=4. out_tready toggles randomly (seeded 50%) over 100 beats → the scoreboard's expected lane stream matches exactly. Each out_tdata is held stable while out_tvalid=1 & out_tready=0.
- tlast placement, n=1, ratio=2. Packet of 3 wide beats with in_tlast only on the third → out_tlast asserted only on narrow beat 6.
- Async reset, n=1, ratio=4. Assert reset_n=0 mid-beat after lane BB is accepted → out_tvalid drops within the same cycle, with no clock edge required. After release, a new beat 32'h44332211 emits 11, 22, 33, 44.
- ratio=1, n=2. Stream 16'h1234, 16'h5678 with out_tready stalled for 3 cycles → outputs 1234 then 5678, each 1 cycle after its handshake, with no duplication or loss.
